// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Requester A is the ALU result path and requester B is the load path.
// Grants are combinational valid/ready handshakes. The chosen write is
// registered onto wb_*, and wb_sel drives the destination-address mux select.
// A saturating counter records the cycles in which both requesters compete.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              wb_stall,
  output logic              wb_en,
  output logic              wb_sel,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  conflict_count
);

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  // Identity of the most recent grant. It resets to B so that A wins the first tie.
  logic              last_grant;

  logic              grant_valid_c;
  logic              grant_id_c;
  logic [ADDR_W-1:0] grant_addr_c;
  logic [DATA_W-1:0] grant_data_c;
  logic              conflict_c;

  // Grant selection: at most one ready, only to a valid requester, none while stalled.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!wb_stall) begin
      if (a_valid && b_valid) begin
        if (last_grant == GRANT_B) begin
          a_ready = 1'b1;
        end else begin
          b_ready = 1'b1;
        end
      end else if (a_valid) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  // Payload mux for the granted requester, plus conflict detection.
  always_comb begin
    grant_valid_c = a_ready | b_ready;
    grant_id_c    = b_ready ? GRANT_B : GRANT_A;
    grant_addr_c  = b_ready ? b_addr : a_addr;
    grant_data_c  = b_ready ? b_data : a_data;
    conflict_c    = a_valid & b_valid & ~wb_stall;
  end

  // Registered write stage. A grant to $zero is consumed: round-robin state
  // advances, but the port stays disabled and the previous address and data hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_en      <= 1'b0;
      wb_sel     <= GRANT_A;
      wb_addr    <= '0;
      wb_data    <= '0;
      last_grant <= GRANT_B;
    end else begin
      wb_en <= 1'b0;
      if (grant_valid_c) begin
        last_grant <= grant_id_c;
        wb_sel     <= grant_id_c;
        if (grant_addr_c != ZERO_ADDR) begin
          wb_en   <= 1'b1;
          wb_addr <= grant_addr_c;
          wb_data <= grant_data_c;
        end
      end
    end
  end

  // Saturating conflict counter for performance debug.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_count <= '0;
    end else if (conflict_c && (conflict_count != CNT_MAX)) begin
      conflict_count <= conflict_count + CNT_W'(1);
    end
  end

endmodule
